i2c_key_master: RTL and testbench
=================================

# i2c_key_master

Bus-initiating counterpart of the I2C key-receiving slave: writes a 128-bit key as one I2C write transaction (START, 7-bit address + W, 16 data bytes MSB-first, STOP) onto an open-drain SCL/SDA pair. It sits on the host/test side of the key interface and drives the same bus the slave's `scl`/`sda_in`/`sda_out` pins attach to. Completion or a NACK is reported with single-cycle pulses.

## Interface
- `CLK_DIV`, 25: `clk` cycles per SCL quarter-period (phase); legal range 2..1023.
- `SLAVE_ADDR`, 7'h3C: 7-bit target address sent in the address byte.
- `clk`  input  1  system clock; all logic on rising edge.
- `n_rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request pulse; accepted only while `busy`=0.
- `key_data`  input  128  key to send; captured on the accepted `start` cycle.
- `sda_in`  input  1  synchronised SDA line level (ACK sampling, stretch-free).
- `scl_in`  input  1  synchronised SCL line level (used only with `I2C_CLK_STRETCH_EN`).
- `scl_out`  output  1  0 = pull SCL low, 1 = release.
- `sda_out`  output  1  0 = pull SDA low, 1 = release.
- `busy`  output  1  high from the cycle after acceptance until transaction end.
- `done`  output  1  one-cycle pulse: all 17 bytes ACKed and STOP sent.
- `nack_error`  output  1  one-cycle pulse: NACK seen, STOP sent, transfer aborted.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- IDLE: `scl_out`=`sda_out`=1. `start`=1 latches `key_data` into a 128-bit shift register, clears the byte counter, enters START.
- Every bit slot = 4 phases (P0..P3), each `CLK_DIV` clocks. SCL low in P0,P1; released in P2,P3. SDA updated only at entry to P0.
- START: P0 SDA=1/SCL=1; P1,P2 SDA=0/SCL=1; P3 SDA=0/SCL=0.
- ADDR: 8 slots sending `{SLAVE_ADDR,1'b0}` MSB first.
- ACK slots (ADDR_ACK, DATA_ACK): `sda_out`=1; `sda_in` sampled on the last clock of P2. 0 = ACK, 1 = NACK.
- DATA: 8 slots per byte from key bits [127:120] first; shift left 8 per byte; 4-bit counter 0..15.
- After ACK: byte counter <15 → DATA; after 16th data ACK → STOP.
- Any NACK → STOP with abort flag set; remaining bytes not sent.
- STOP: P0 SDA=0/SCL=0; P1 SDA=0/SCL=1; P2,P3 SDA=1/SCL=1; then IDLE.
- `start` while `busy`=1 is ignored (no queueing). `key_data` changes after acceptance have no effect.

## Timing
- Reset values: `scl_out`=1, `sda_out`=1, `busy`=0, `done`=0, `nack_error`=0; state IDLE, counters 0.
- Reset asserted mid-transfer: lines released immediately (asynchronous); no STOP generated.
- `busy` rises the cycle after `start` is accepted.
- Successful transfer: START 4 phases + 17 × 9 slots × 4 phases + STOP 4 phases = 620 × `CLK_DIV` clocks of `busy`.
- Final STOP P3 ends → next cycle IDLE, `busy`=0 and exactly one of `done`/`nack_error` pulses that cycle.
- Address NACK: `busy` lasts (4 + 36 + 4) × `CLK_DIV` clocks.
- `start` in the same cycle `busy` falls is accepted (back-to-back transfers).

## Configuration
- `I2C_CLK_STRETCH_EN` defined: on entry to P2/P3 with `scl_out`=1, the phase counter holds while `scl_in`=0 (slave stretching); ACK sampling occurs only after `scl_in`=1 seen for a full phase.
- Undefined: `scl_in` ignored; timing strictly as above.

## Structure
- Package `i2c_pkg`: state enum `i2c_mstate_t`, `I2C_ADDR_W`=7, `KEY_BYTES`=16, `PHASES_PER_BIT`=4.
- Sub-module `i2c_phase_gen`: divider emitting `phase_tick` and 2-bit `phase`, with hold input for stretching.

## Test plan
- `CLK_DIV`=4, key 128'h00112233445566778899AABBCCDDEEFF, slave model ACKs all → bytes 0x78, 0x00 … 0xFF decoded; `done` pulses once after 2480 clocks; `nack_error`=0.
- Slave NACKs address → STOP after 176 clocks; `nack_error` pulse; no data bits driven.
- Slave NACKs 5th data byte → STOP follows that ACK slot; `nack_error` pulse; bytes 6–16 absent.
- `start` re-pulsed while `busy` and `key_data` changed → first key sent unaltered, single `done`.
- `n_rst` low mid-DATA → `scl_out`=`sda_out`=1 immediately, `busy`=0; next `start` runs a clean full transfer.
- With `I2C_CLK_STRETCH_EN`, slave holds SCL low 20 clocks during byte 3 → transfer extended by 20 clocks, data intact, `done` pulses.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C key master.
// Optional feature macro used by the design: I2C_CLK_STRETCH_EN.
package i2c_pkg;

    localparam int I2C_ADDR_W     = 7;
    localparam int KEY_BYTES      = 16;
    localparam int KEY_W          = KEY_BYTES * 8;
    localparam int PHASES_PER_BIT = 4;
    localparam int PHASE_W        = $clog2(PHASES_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } i2c_mstate_t;

    // Line levels {scl, sda} for a given state/phase; b is the bit being sent.
    function automatic logic [1:0] slot_lines(i2c_mstate_t st, logic [PHASE_W-1:0] ph, logic b);
        logic [1:0] r;
        r = 2'b11;
        case (st)
            ST_START: begin
                case (ph)
                    2'd0:       r = 2'b11;
                    2'd1, 2'd2: r = 2'b10;
                    default:    r = 2'b00;
                endcase
            end
            ST_STOP: begin
                case (ph)
                    2'd0:    r = 2'b00;
                    2'd1:    r = 2'b10;
                    default: r = 2'b11;
                endcase
            end
            ST_ADDR, ST_DATA:         r = {ph[1], b};
            ST_ADDR_ACK, ST_DATA_ACK: r = {ph[1], 1'b1};
            default:                  r = 2'b11;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: divides clk into SCL quarter-period phases.
// Emits a one-cycle phase_tick_o on the last clock of each phase and the
// current 2-bit phase index. hold_i freezes the divider at the start of a
// phase (used for slave clock stretching).
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               run_i,
    input  logic               hold_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               phase_tick_o
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0]      cnt_q;
    logic [PHASE_W-1:0] phase_q;
    logic               stall;

    // Holding only while the count sits at zero means a stretched phase
    // still gets its full CLK_DIV clocks once SCL is seen high.
    assign stall        = hold_i && (cnt_q == '0);
    assign phase_tick_o = run_i && (cnt_q == CNT_LAST);
    assign phase_o      = phase_q;

    // Divider counter and phase index; cleared whenever the master is idle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else if (!run_i) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else if (stall) begin
            cnt_q   <= cnt_q;
        end else if (phase_tick_o) begin
            cnt_q   <= '0;
            phase_q <= phase_q + 1'b1;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_key_master.sv
// i2c_key_master: writes a 128-bit key as one I2C write transaction
// (START, address+W, 16 data bytes MSB-first, STOP) on open-drain lines.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching via scl_in.
module i2c_key_master
    import i2c_pkg::*;
#(
    parameter int                    CLK_DIV    = 25,
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h3C
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_data,
    input  logic             sda_in,
    input  logic             scl_in,
    output logic             scl_out,
    output logic             sda_out,
    output logic             busy,
    output logic             done,
    output logic             nack_error
);

    i2c_mstate_t        state_q;
    logic [2:0]         bit_q;
    logic [3:0]         byte_q;
    logic [KEY_W-1:0]   key_q;
    logic               abort_q;
    logic               nack_q;
    logic               scl_q, sda_q;
    logic               busy_q, done_q, nack_err_q;

    logic [PHASE_W-1:0] phase;
    logic               phase_tick;
    logic               hold;
    logic [PHASE_W-1:0] nxt_ph;
    logic [2:0]         nbit;
    logic [7:0]         addr_w;
    logic [7:0]         key_top;

    assign nxt_ph  = phase + 1'b1;
    assign nbit    = bit_q + 3'd1;
    assign addr_w  = {SLAVE_ADDR, 1'b0};
    assign key_top = key_q[KEY_W-1 -: 8];

`ifdef I2C_CLK_STRETCH_EN
    // While we release SCL in the high phases, a low line means the slave stretches.
    assign hold = scl_q && !scl_in && phase[1];
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    i2c_phase_gen #(
        .CLK_DIV      (CLK_DIV)
    ) u_phase (
        .clk          (clk),
        .n_rst        (n_rst),
        .run_i        (busy_q),
        .hold_i       (hold),
        .phase_o      (phase),
        .phase_tick_o (phase_tick)
    );

    // Transaction FSM; line levels are registered for the phase being entered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            byte_q     <= '0;
            key_q      <= '0;
            abort_q    <= 1'b0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start) begin
                    state_q <= ST_START;
                    key_q   <= key_data;
                    byte_q  <= '0;
                    bit_q   <= '0;
                    abort_q <= 1'b0;
                    nack_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    {scl_q, sda_q} <= slot_lines(ST_START, 2'd0, 1'b1);
                end
            end else if (phase_tick) begin
                case (state_q)
                    ST_START: begin
                        if (phase == 2'd3) begin
                            state_q <= ST_ADDR;
                            bit_q   <= '0;
                            {scl_q, sda_q} <= slot_lines(ST_ADDR, 2'd0, addr_w[7]);
                        end else begin
                            {scl_q, sda_q} <= slot_lines(ST_START, nxt_ph, 1'b1);
                        end
                    end
                    ST_ADDR: begin
                        if (phase == 2'd3) begin
                            if (bit_q == 3'd7) begin
                                state_q <= ST_ADDR_ACK;
                                {scl_q, sda_q} <= slot_lines(ST_ADDR_ACK, 2'd0, 1'b1);
                            end else begin
                                bit_q <= nbit;
                                {scl_q, sda_q} <= slot_lines(ST_ADDR, 2'd0, addr_w[~nbit]);
                            end
                        end else begin
                            {scl_q, sda_q} <= slot_lines(ST_ADDR, nxt_ph, addr_w[~bit_q]);
                        end
                    end
                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (phase == 2'd2) begin
                            nack_q <= sda_in;
                        end
                        if (phase == 2'd3) begin
                            if (nack_q) begin
                                state_q <= ST_STOP;
                                abort_q <= 1'b1;
                                {scl_q, sda_q} <= slot_lines(ST_STOP, 2'd0, 1'b1);
                            end else if (state_q == ST_DATA_ACK && byte_q == 4'(KEY_BYTES - 1)) begin
                                state_q <= ST_STOP;
                                {scl_q, sda_q} <= slot_lines(ST_STOP, 2'd0, 1'b1);
                            end else begin
                                // The key is pre-shifted, so the next byte is always on top.
                                if (state_q == ST_DATA_ACK) begin
                                    byte_q <= byte_q + 4'd1;
                                end
                                state_q <= ST_DATA;
                                bit_q   <= '0;
                                {scl_q, sda_q} <= slot_lines(ST_DATA, 2'd0, key_top[7]);
                            end
                        end else begin
                            {scl_q, sda_q} <= slot_lines(state_q, nxt_ph, 1'b1);
                        end
                    end
                    ST_DATA: begin
                        if (phase == 2'd3) begin
                            if (bit_q == 3'd7) begin
                                state_q <= ST_DATA_ACK;
                                key_q   <= key_q << 8;
                                {scl_q, sda_q} <= slot_lines(ST_DATA_ACK, 2'd0, 1'b1);
                            end else begin
                                bit_q <= nbit;
                                {scl_q, sda_q} <= slot_lines(ST_DATA, 2'd0, key_top[~nbit]);
                            end
                        end else begin
                            {scl_q, sda_q} <= slot_lines(ST_DATA, nxt_ph, key_top[~bit_q]);
                        end
                    end
                    ST_STOP: begin
                        if (phase == 2'd3) begin
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                            done_q     <= !abort_q;
                            nack_err_q <= abort_q;
                            scl_q      <= 1'b1;
                            sda_q      <= 1'b1;
                        end else begin
                            {scl_q, sda_q} <= slot_lines(ST_STOP, nxt_ph, 1'b1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        scl_q   <= 1'b1;
                        sda_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign scl_out    = scl_q;
    assign sda_out    = sda_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign nack_error = nack_err_q;

endmodule

// File: tb/tb_i2c_key_master.sv
// tb_i2c_key_master: randomized key transfers against a bus-level slave
// model that decodes START/STOP and bytes from the wires and ACKs/NACKs
// on demand; expected bytes and timings come from transaction arithmetic.
module tb_i2c_key_master;

    localparam int CLK_DIV = 4;
    localparam logic [6:0] ADDR = 7'h3C;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_data = '0;
    logic         sda_in, scl_in, scl_out, sda_out, busy, done, nack_error;

    int total = 0;
    int bad = 0;

    // slave / bus model state
    logic       slave_sda = 1'b1;
    logic       p_scl = 1'b1, p_sda = 1'b1;
    logic [7:0] shreg = '0;
    int         bitcnt = 0;
    int         starts = 0, stops = 0;
    logic [7:0] rx[$];
    int         nack_at = -1;
    int         stretch_byte = -1;
    bit         stretch_arm = 1'b0;
    int         stretch_cnt = 0;

    wire scl_line = scl_out & ~(stretch_arm && stretch_cnt < 20);
    wire sda_line = sda_out & slave_sda;
    assign sda_in = sda_line;
    assign scl_in = scl_line;

    always #5 clk = ~clk;

    i2c_key_master #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(ADDR)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .key_data(key_data),
        .sda_in(sda_in), .scl_in(scl_in), .scl_out(scl_out), .sda_out(sda_out),
        .busy(busy), .done(done), .nack_error(nack_error)
    );

    // bus decoder + ACK driver + optional clock stretcher
    always @(posedge clk) begin
        p_scl <= scl_line;
        p_sda <= sda_line;
        if (stretch_arm && scl_out && stretch_cnt < 20) stretch_cnt <= stretch_cnt + 1;
        if (scl_line && p_scl && p_sda && !sda_line) begin
            bitcnt <= 0;
            starts <= starts + 1;
        end else if (scl_line && p_scl && !p_sda && sda_line) begin
            stops <= stops + 1;
        end else if (scl_line && !p_scl) begin
            if (bitcnt < 8) begin
                shreg  <= {shreg[6:0], sda_line};
                bitcnt <= bitcnt + 1;
                if (bitcnt == 7) rx.push_back({shreg[6:0], sda_line});
            end else begin
                bitcnt <= 0;
            end
        end else if (!scl_line && p_scl) begin
            if (bitcnt == 8) slave_sda <= (rx.size() == nack_at) ? 1'b1 : 1'b0;
            else             slave_sda <= 1'b1;
            if (rx.size() == stretch_byte && bitcnt == 2 && !stretch_arm) stretch_arm <= 1'b1;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [127:0] k, input int i);
        logic [7:0] r;
        if (i == 0) r = {ADDR, 1'b0};
        else        r = k[127 - 8*(i-1) -: 8];
        return r;
    endfunction

    // One transfer; nack_pos = 1-based byte index the slave NACKs (0 = none).
    task automatic do_xfer(input logic [127:0] k, input int nack_pos, input int extra,
                           input bit restart, input string nm);
        int base, nb, bexp, bcnt, dcnt, ncnt, s0, n;
        bit end_done, end_nack, fin;
        base = rx.size();
        s0   = stops;
        nb   = (nack_pos == 0) ? 17 : nack_pos;
        bexp = (8 + 36 * nb) * CLK_DIV + extra;
        nack_at = (nack_pos == 0) ? -1 : base + nack_pos;
        bcnt = 0; dcnt = 0; ncnt = 0; fin = 0; end_done = 0; end_nack = 0;
        @(negedge clk);
        start = 1'b1; key_data = k;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            if (restart && bcnt == 300) begin start = 1'b1; key_data = ~k; end
            if (restart && bcnt == 301) start = 1'b0;
            if (done) dcnt++;
            if (nack_error) ncnt++;
            if (busy) bcnt++;
            else begin fin = 1; end_done = done; end_nack = nack_error; end
            if (!fin) @(negedge clk);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (nack_error) ncnt++;
        end
        total++;
        if (!fin) begin bad++; $display("FAIL %s timeout: busy never fell", nm); end
        total++;
        if (bcnt !== bexp) begin bad++; $display("FAIL %s busy_len got=%0d want=%0d", nm, bcnt, bexp); end
        total++;
        if (end_done !== (nack_pos == 0) || end_nack !== (nack_pos != 0)) begin
            bad++; $display("FAIL %s end_pulse done=%0b nack=%0b want_nack=%0b", nm, end_done, end_nack, nack_pos != 0);
        end
        total++;
        if (dcnt !== ((nack_pos == 0) ? 1 : 0) || ncnt !== ((nack_pos == 0) ? 0 : 1)) begin
            bad++; $display("FAIL %s pulse_count done=%0d nack=%0d", nm, dcnt, ncnt);
        end
        total++;
        if (stops - s0 !== 1) begin bad++; $display("FAIL %s stop_count got=%0d want=1", nm, stops - s0); end
        n = rx.size() - base;
        total++;
        if (n !== nb) begin bad++; $display("FAIL %s byte_count got=%0d want=%0d", nm, n, nb); end
        for (int i = 0; i < nb && i < n; i++) begin
            total++;
            if (rx[base + i] !== exp_byte(k, i)) begin
                bad++; $display("FAIL %s byte[%0d] got=%02h want=%02h", nm, i, rx[base + i], exp_byte(k, i));
            end
        end
        nack_at = -1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #23;
        total++;
        if ({scl_out, sda_out, busy, done, nack_error} !== 5'b11000) begin
            bad++; $display("FAIL reset_state got=%05b want=11000", {scl_out, sda_out, busy, done, nack_error});
        end
        @(negedge clk); n_rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({scl_out, sda_out, busy} !== 3'b110) begin
            bad++; $display("FAIL idle_state got=%03b want=110", {scl_out, sda_out, busy});
        end
    endtask

    task automatic test_full();
        do_xfer(128'h00112233445566778899AABBCCDDEEFF, 0, 0, 0, "full");
    endtask

    task automatic test_random();
        logic [127:0] k;
        int np;
        for (int it = 0; it < 5; it++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            np = (it == 0) ? 0 : int'($urandom_range(0, 17));
            do_xfer(k, np, 0, 0, "random");
        end
    endtask

    task automatic test_addr_nack();
        do_xfer({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, "addr_nack");
    endtask

    task automatic test_data_nack();
        do_xfer({$urandom, $urandom, $urandom, $urandom}, 6, 0, 0, "data_nack");
    endtask

    task automatic test_ignore_restart();
        do_xfer({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, "restart_ignored");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; key_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        repeat (126 * CLK_DIV + 1) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_mid pre busy got=%0b want=1", busy); end
        n_rst = 1'b0;
        #1;
        total++;
        if ({scl_out, sda_out, busy} !== 3'b110) begin
            bad++; $display("FAIL reset_mid lines got=%03b want=110", {scl_out, sda_out, busy});
        end
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        do_xfer({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1, k2;
        int base, gap, b2;
        bit ok;
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        base = rx.size();
        @(negedge clk);
        start = 1'b1; key_data = k1;
        @(negedge clk);
        key_data = k2;
        ok = 0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        total++;
        if (!ok || done !== 1'b1) begin bad++; $display("FAIL b2b first_done got=%0b want=1", done); end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b reaccept busy got=%0b want=1", busy); end
        gap = 0; b2 = 1; ok = 0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            @(negedge clk);
            if (busy) b2++; else ok = 1;
        end
        total++;
        if (!ok || done !== 1'b1 || b2 !== 620 * CLK_DIV) begin
            bad++; $display("FAIL b2b second got_done=%0b busy_len=%0d want=%0d", done, b2, 620 * CLK_DIV);
        end
        total++;
        if (rx.size() - base !== 34) begin bad++; $display("FAIL b2b bytes got=%0d want=34", rx.size() - base); end
        for (int i = 0; i < 17 && base + 17 + i < rx.size(); i++) begin
            total++;
            if (rx[base + i] !== exp_byte(k1, i) || rx[base + 17 + i] !== exp_byte(k2, i)) begin
                bad++; $display("FAIL b2b byte[%0d] got=%02h/%02h want=%02h/%02h", i,
                                rx[base + i], rx[base + 17 + i], exp_byte(k1, i), exp_byte(k2, i));
            end
        end
        gap = gap + 0;
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        stretch_byte = rx.size() + 3;
        do_xfer({$urandom, $urandom, $urandom, $urandom}, 0, 20, 0, "stretch");
        total++;
        if (stretch_cnt !== 20) begin bad++; $display("FAIL stretch hold_cycles got=%0d want=20", stretch_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_full();
        test_addr_nack();
        test_data_nack();
        test_random();
        test_ignore_restart();
        test_reset_mid();
        test_back_to_back();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
